out_requant: RTL and testbench
==============================

# out_requant

Post-processing stage directly downstream of `macarray`. When `macarray` finishes, this block reads the 16-bit signed T×M result matrix from the output SRAM. It applies ReLU, an arithmetic right shift and saturation to int8, then writes the packed 8-bit rows into an 8-entry next-layer input SRAM. That SRAM uses the same row format `macarray` consumes as input, so layers can be chained.

## Interface
Parameters: none; the geometry is fixed.
- `CLK`  in  1  Single clock; everything is sampled on the rising edge.
- `RSTN`  in  1  Asynchronous, active-low reset.
- `START`  in  1  Start strobe; sampled only in IDLE.
- `MNT`  in  12  Matrix dimensions: M=`MNT[11:8]`, T=`MNT[3:0]`; `MNT[7:4]` (N) is ignored. Latched on accepted START.
- `SHIFT`  in  4  Right-shift amount; latched on accepted START.
- `BUSY`  out  1  High from the cycle after an accepted START through the DONE cycle inclusive.
- `DONE`  out  1  One-cycle completion pulse.
- `EN_O`  out  1  Read enable to the output SRAM (drives its CSN through inversion; its WEN is tied high).
- `ADDR_O`  out  4  Output SRAM read address.
- `RDATA_O`  in  64  Output SRAM read data, valid the cycle after `EN_O`.
- `EN_N`  out  1  Enable to the next-layer SRAM.
- `RW_N`  out  1  Write strobe to the next-layer SRAM (1 = write; the block only writes).
- `ADDR_N`  out  3  Next-layer SRAM address.
- `WDATA_N`  out  64  Next-layer SRAM write data.

## Operation
- Source layout: result (r,c), 0-based, is at address 2r+(c>>2), lane c&3, bits [63-16·(c&3) -: 16], signed.
- Destination layout: row r is at address r, column c is at bits [63-8c -: 8].
- Clamping: M and T values of 9–15 are clamped to 8. A value of 0 is legal and means no valid data.
- Per element: `y = (x<0) ? 0 : x>>>SHIFT`, then `y>127 ? 127 : y`.
  - Columns c≥M produce 0x00.
- States: IDLE, RD0, RD1, CAP, WR, FIN. A row counter r (0–7) runs alongside.
- IDLE → RD0 on START if T>0, otherwise IDLE → WR. In both cases r is cleared and MNT and SHIFT are latched.
- RD0: `EN_O`=1, `ADDR_O`=2r.
- RD1: `EN_O`=1, `ADDR_O`=2r+1. Capture `RDATA_O` as columns 0–3.
- CAP: capture `RDATA_O` as columns 4–7.
- WR: `EN_N`=1, `RW_N`=1, `ADDR_N`=r, `WDATA_N`=packed row.
  - For r≥T the row is all zeros and no reads are issued.
  - If r==7, go to FIN. Otherwise increment r and go to RD0 if r+1<T, else WR.
- FIN: `DONE`=1, then return to IDLE.
- All 8 destination rows are always written; padding rows are written with zeros.
- `EN_O` is never asserted for addresses ≥2T.
- START while BUSY is ignored. MNT and SHIFT changes during BUSY have no effect.

## Timing
- Outputs are Moore-decoded from the state register and latched data; there is no combinational input-to-output path.
- Reset values: `BUSY`, `DONE`, `EN_O`, `EN_N` and `RW_N` are 0; `ADDR_O`, `ADDR_N` and `WDATA_N` are all zero; the state is IDLE.
- Cycle numbering: the START sample edge is cycle 0.
  - Cycles 1..4T: data rows, 4 cycles each.
  - Cycles 4T+1..4T+(8−T): zero rows, 1 cycle each.
  - `DONE` is high in cycle 3T+9. For T=3 that is cycle 18; for T=8, cycle 33; for T=0, cycle 9.
- Source read latency is 1 cycle: data addressed in cycle k is captured at the end of cycle k+1.
- Reset asserted mid-operation: return immediately to IDLE, with all outputs at their reset values. No further reads or writes occur; the partially written destination is not repaired.
- A new START is accepted in the cycle after FIN, i.e. with IDLE ≥1 cycle.

## Test plan
- Basic row: MNT=12'h763, SHIFT=0. Address 0 holds 64'h0005_FFFF_0080_7FFF and address 1 holds 64'h0001_0002_0003_0004 → write at `ADDR_N`=0 with data 64'h05_00_7F_7F_01_02_03_00 (column 7 zeroed because M=7).
- Shift: SHIFT=4, address 0 = 64'h0100_07F0_0800_8000 → bytes 0x10, 0x7F, 0x7F, 0x00.
- Sequence check for MNT=12'h763:
  - `ADDR_O` sequence is 0,1,2,3,4,5.
  - Writes go to `ADDR_N` 0..7, with rows 3–7 equal to 0.
  - `DONE` is exactly at cycle 18.
  - `BUSY` spans cycles 1–18.
- Full size: MNT=12'h888 → 16 reads, 8 data writes, `DONE` at cycle 33.
- T=0 (MNT=12'h880) → 8 zero writes, `DONE` at cycle 9, `EN_O` never asserted.
- Robustness:
  - A second START at cycle 5 is ignored.
  - `RSTN` pulsed low at cycle 7 → all outputs go to 0 with no further writes.
  - After release, a new START completes with correct data and `DONE` timing.

Source files
------------

// File: rtl/out_requant.sv
// out_requant: ReLU, shift and int8 saturation of a 16-bit result matrix into a next-layer SRAM
module out_requant (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START,
    input  logic [11:0] MNT,
    input  logic [3:0]  SHIFT,
    output logic        BUSY,
    output logic        DONE,
    output logic        EN_O,
    output logic [3:0]  ADDR_O,
    input  logic [63:0] RDATA_O,
    output logic        EN_N,
    output logic        RW_N,
    output logic [2:0]  ADDR_N,
    output logic [63:0] WDATA_N
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, WR, FIN} state_t;
    state_t      state_q, state_d;
    logic [2:0]  r_q, r_d;
    logic [3:0]  m_q, m_d, t_q, t_d, sh_q, sh_d;
    logic [63:0] lo_q, lo_d, row_d;
    logic        en_o_d, wr_d;
    logic [3:0]  addr_o_d;
    logic [2:0]  addr_n_d;
    logic        unused_n;
    assign unused_n = ^MNT[7:4];
    function automatic logic [3:0] clamp8(input logic [3:0] v);
        return v > 4'd8 ? 4'd8 : v;
    endfunction
    function automatic logic [63:0] pack(input logic [127:0] src, input logic [3:0] m, input logic [3:0] sh);
        logic [15:0] x, y;
        pack = '0;
        for (int c = 0; c < 8; c++) begin
            x = src[127-16*c -: 16];
            y = x >> sh;
            pack[63-8*c -: 8] = (x[15] || 4'(c) >= m) ? 8'd0 : (y > 16'd127 ? 8'd127 : y[7:0]);
        end
    endfunction
    // next-state sequencing: read two halves of a data row, then write it; padding rows write zeros
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        m_d     = m_q;
        t_d     = t_q;
        sh_d    = sh_q;
        lo_d    = lo_q;
        row_d   = '0;
        case (state_q)
            IDLE: if (START) begin
                r_d     = '0;
                m_d     = clamp8(MNT[11:8]);
                t_d     = clamp8(MNT[3:0]);
                sh_d    = SHIFT;
                state_d = clamp8(MNT[3:0]) != 4'd0 ? RD0 : WR;
            end
            RD0: state_d = RD1;
            RD1: begin
                lo_d    = RDATA_O;
                state_d = CAP;
            end
            CAP: begin
                row_d   = pack({lo_q, RDATA_O}, m_q, sh_q);
                state_d = WR;
            end
            WR: if (r_q == 3'd7) state_d = FIN;
                else begin
                    r_d     = r_q + 3'd1;
                    state_d = ({1'b0, r_q} + 4'd1 < t_q) ? RD0 : WR;
                end
            default: state_d = IDLE;
        endcase
    end
    assign en_o_d   = state_d == RD0 || state_d == RD1;
    assign addr_o_d = en_o_d ? {r_d, state_d == RD1} : 4'd0;
    assign wr_d     = state_d == WR;
    assign addr_n_d = wr_d ? r_d : 3'd0;
    // state, latched parameters and outputs registered from next-state so outputs have no input path
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            r_q     <= '0;
            m_q     <= '0;
            t_q     <= '0;
            sh_q    <= '0;
            lo_q    <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            EN_O    <= 1'b0;
            ADDR_O  <= '0;
            EN_N    <= 1'b0;
            RW_N    <= 1'b0;
            ADDR_N  <= '0;
            WDATA_N <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            m_q     <= m_d;
            t_q     <= t_d;
            sh_q    <= sh_d;
            lo_q    <= lo_d;
            BUSY    <= state_d != IDLE;
            DONE    <= state_d == FIN;
            EN_O    <= en_o_d;
            ADDR_O  <= addr_o_d;
            EN_N    <= wr_d;
            RW_N    <= wr_d;
            ADDR_N  <= addr_n_d;
            WDATA_N <= row_d;
        end
    end
endmodule

// File: tb/tb_out_requant.sv
// tb_out_requant: directed checks of out_requant data, sequencing, timing and reset behaviour
module tb_out_requant;
    logic        CLK = 1'b0, RSTN = 1'b0, START = 1'b0;
    logic [11:0] MNT = '0;
    logic [3:0]  SHIFT = '0;
    logic        BUSY, DONE, EN_O, EN_N, RW_N;
    logic [3:0]  ADDR_O;
    logic [2:0]  ADDR_N;
    logic [63:0] RDATA_O = '0, WDATA_N;
    logic [63:0] src [16];
    logic [63:0] exp_row [8];
    int          n_chk = 0, n_fail = 0;
    int          rd_q[$], wa_q[$];
    logic [63:0] wd_q[$];
    int          done_cyc, done_cnt, busy_first, busy_last, busy_cnt;

    out_requant dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .MNT(MNT), .SHIFT(SHIFT),
        .BUSY(BUSY), .DONE(DONE), .EN_O(EN_O), .ADDR_O(ADDR_O), .RDATA_O(RDATA_O),
        .EN_N(EN_N), .RW_N(RW_N), .ADDR_N(ADDR_N), .WDATA_N(WDATA_N)
    );

    always #5 CLK = ~CLK;

    // output SRAM model with one cycle read latency
    always @(posedge CLK) if (EN_O) RDATA_O <= src[ADDR_O];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
    endtask

    task automatic sample(input int k);
        if (EN_O) rd_q.push_back(int'(ADDR_O));
        if (EN_N && RW_N) begin wa_q.push_back(int'(ADDR_N)); wd_q.push_back(WDATA_N); end
        if (DONE) begin done_cyc = k; done_cnt++; end
        if (BUSY) begin if (busy_first < 0) busy_first = k; busy_last = k; busy_cnt++; end
    endtask

    task automatic run(input logic [11:0] mnt, input logic [3:0] sh, input bit disturb);
        @(negedge CLK);
        MNT = mnt; SHIFT = sh; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        clear_logs();
        for (int k = 1; k <= 40; k++) begin
            sample(k);
            if (disturb && k == 4) begin START = 1'b1; MNT = 12'h111; SHIFT = 4'hF; end
            if (disturb && k == 5) START = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic verify(input string name, input int n_rd, input int t_done);
        check({name, " nreads"}, 64'(rd_q.size()), 64'(n_rd));
        foreach (rd_q[i]) check({name, " raddr"}, 64'(rd_q[i]), 64'(i));
        check({name, " nwrites"}, 64'(wa_q.size()), 64'd8);
        foreach (wa_q[i]) begin
            check({name, " waddr"}, 64'(wa_q[i]), 64'(i));
            if (i < 8) check({name, " wdata"}, wd_q[i], exp_row[i]);
        end
        check({name, " done_cyc"}, 64'(done_cyc), 64'(t_done));
        check({name, " done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, " busy_first"}, 64'(busy_first), 64'd1);
        check({name, " busy_last"}, 64'(busy_last), 64'(t_done));
        check({name, " busy_cnt"}, 64'(busy_cnt), 64'(t_done));
    endtask

    task automatic check_idle_outs(input string name);
        check({name, " busy"}, 64'(BUSY), 64'd0);
        check({name, " done"}, 64'(DONE), 64'd0);
        check({name, " en_o"}, 64'(EN_O), 64'd0);
        check({name, " en_n"}, 64'(EN_N), 64'd0);
        check({name, " rw_n"}, 64'(RW_N), 64'd0);
        check({name, " addr_o"}, 64'(ADDR_O), 64'd0);
        check({name, " addr_n"}, 64'(ADDR_N), 64'd0);
        check({name, " wdata_n"}, WDATA_N, 64'd0);
    endtask

    task automatic load_basic();
        for (int a = 0; a < 16; a++) src[a] = 64'h1111_2222_3333_4444;
        src[0] = 64'h0005_FFFF_0080_7FFF;
        src[1] = 64'h0001_0002_0003_0004;
        src[2] = 64'h0000_0010_0040_0100;
        src[3] = 64'h8000_007F_0000_0001;
        src[4] = 64'h0011_0022_0033_0044;
        src[5] = 64'h0055_0066_0077_0088;
        foreach (exp_row[i]) exp_row[i] = '0;
        exp_row[0] = 64'h05_00_7F_7F_01_02_03_00;
        exp_row[1] = 64'h00_10_40_7F_00_7F_00_00;
        exp_row[2] = 64'h11_22_33_44_55_66_77_00;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_idle_outs("reset");
        RSTN = 1'b1;

        load_basic();
        run(12'h763, 4'd0, 1'b1);
        verify("basic", 6, 18);

        for (int a = 0; a < 16; a++) src[a] = 64'h1111_2222_3333_4444;
        src[0] = 64'h0100_07F0_0800_8000;
        src[1] = 64'h7FFF_0FFF_0010_000F;
        foreach (exp_row[i]) exp_row[i] = '0;
        exp_row[0] = 64'h10_7F_7F_00_7F_7F_01_00;
        run(12'h841, 4'd4, 1'b0);
        verify("shift", 2, 12);

        for (int a = 0; a < 16; a++) src[a] = a[0] ? 64'h0005_0006_0007_0008 : 64'h0001_0002_0003_0004;
        foreach (exp_row[i]) exp_row[i] = 64'h0102030405060708;
        run(12'h888, 4'd0, 1'b0);
        verify("full", 16, 33);

        foreach (exp_row[i]) exp_row[i] = '0;
        run(12'h880, 4'd0, 1'b0);
        verify("t0", 0, 9);

        load_basic();
        @(negedge CLK);
        MNT = 12'h763; SHIFT = 4'd0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        RSTN = 1'b0;
        #1;
        check_idle_outs("midreset");
        @(negedge CLK);
        RSTN = 1'b1;
        clear_logs();
        for (int k = 1; k <= 12; k++) begin
            sample(k);
            @(negedge CLK);
        end
        check("post_reset nreads", 64'(rd_q.size()), 64'd0);
        check("post_reset nwrites", 64'(wa_q.size()), 64'd0);
        check("post_reset busy", 64'(busy_cnt), 64'd0);

        run(12'h763, 4'd0, 1'b0);
        verify("restart", 6, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
